// File: rtl/rgmii_tx_scheduler.sv
// -----------------------------------------------------------------------------
// rgmii_tx_scheduler
//
// Purpose: Arbitrates between two byte-stream requesters and frames the
// granted stream for a byte-wide RGMII transmit path. Each frame is sent as
// PRE_BYTES bytes of 0x55, one 0xD5 SFD byte, the payload, and then
// IFG_BYTES idle slots. A source underrun or a loss of link mid-frame ends
// the frame with a single TxEr slot. All sequential activity advances only
// on byte-slot strobes (ClkEn) so one netlist serves 10/100/1000 rates.
//
// Ports:
//   Clk                 single clock
//   Reset_n             synchronous, active-low reset (wins over ClkEn)
//   ClkEn               byte-slot strobe
//   LinkUp              PHY link status
//   Req[1:0]            per-requester frame-pending flag
//   Gnt[1:0]            one-hot grant, registered, held for the frame
//   SrcVld[1:0]         per-requester byte valid
//   SrcLast[1:0]        per-requester last byte of frame
//   SrcData0/SrcData1   requester byte data
//   SrcRd[1:0]          byte pop, combinational
//   TxEn, TxEr, TxData  registered byte-wide transmit outputs
//   Busy                high whenever the FSM is not in IDLE
//   FsmState[2:0]       current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module rgmii_tx_scheduler #(
    parameter int PRE_BYTES = 7,
    parameter int IFG_BYTES = 12
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ClkEn,
    input  logic       LinkUp,
    input  logic [1:0] Req,
    output logic [1:0] Gnt,
    input  logic [1:0] SrcVld,
    input  logic [1:0] SrcLast,
    input  logic [7:0] SrcData0,
    input  logic [7:0] SrcData1,
    output logic [1:0] SrcRd,
    output logic       TxEn,
    output logic       TxEr,
    output logic [7:0] TxData,
    output logic       Busy,
    output logic [2:0] FsmState
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        IFG  = 3'd4
    } state_t;

    // One counter serves both the preamble and the inter-frame gap.
    localparam int CMAX = (PRE_BYTES > IFG_BYTES) ? PRE_BYTES : IFG_BYTES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_BYTES - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rr_last;   // index of the requester granted most recently
    logic          sel;
    logic          vld_g;
    logic          last_g;
    logic [7:0]    data_g;
    logic [1:0]    pick;
    logic          in_frame;
    logic          abort;
    logic          accept;

    // Source handshake: a byte is transferred in a slot when SrcVld[g] and
    // SrcRd[g] are both high; SrcRd is only raised in DATA on a ClkEn cycle
    // with link up, so a source may change SrcVld/SrcLast/SrcData freely
    // while SrcRd is low and must advance to its next byte after each pop.
    always_comb begin
        sel      = Gnt[1];
        vld_g    = SrcVld[sel];
        last_g   = SrcLast[sel];
        data_g   = sel ? SrcData1 : SrcData0;
        in_frame = (state == PRE) || (state == SFD) || (state == DATA);
        // Link loss aborts anywhere inside a frame; a missing byte only
        // matters once payload transfer has begun.
        abort    = in_frame && (!LinkUp || ((state == DATA) && !vld_g));
        accept   = Reset_n && ClkEn && (state == DATA) && LinkUp && vld_g;
        SrcRd    = accept ? Gnt : 2'b00;
        // On a tie the requester that was not served last wins.
        if (Req == 2'b11) begin
            pick = rr_last ? 2'b01 : 2'b10;
        end else begin
            pick = Req;
        end
    end

    assign Busy     = (state != IDLE);
    assign FsmState = state;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            Gnt     <= 2'b00;
            rr_last <= 1'b1;
            TxEn    <= 1'b0;
            TxEr    <= 1'b0;
            TxData  <= 8'h00;
        end else if (ClkEn) begin
            if (abort) begin
                // One error slot, then the normal gap.
                TxEn   <= 1'b1;
                TxEr   <= 1'b1;
                TxData <= 8'h00;
                Gnt    <= 2'b00;
                cnt    <= '0;
                state  <= IFG;
            end else begin
                case (state)
                    IDLE: begin
                        TxEn   <= 1'b0;
                        TxEr   <= 1'b0;
                        TxData <= 8'h00;
                        if (LinkUp && (Req != 2'b00)) begin
                            Gnt     <= pick;
                            rr_last <= pick[1];
                            TxEn    <= 1'b1;
                            TxData  <= 8'h55;
                            if (PRE_BYTES == 1) begin
                                state <= SFD;
                                cnt   <= '0;
                            end else begin
                                state <= PRE;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    PRE: begin
                        // cnt holds the number of preamble bytes already loaded.
                        TxEn   <= 1'b1;
                        TxEr   <= 1'b0;
                        TxData <= 8'h55;
                        if (cnt == PRE_LAST) begin
                            state <= SFD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SFD: begin
                        TxEn   <= 1'b1;
                        TxEr   <= 1'b0;
                        TxData <= 8'hD5;
                        state  <= DATA;
                    end
                    DATA: begin
                        TxEn   <= 1'b1;
                        TxEr   <= 1'b0;
                        TxData <= data_g;
                        if (last_g) begin
                            Gnt   <= 2'b00;
                            cnt   <= '0;
                            state <= IFG;
                        end
                    end
                    IFG: begin
                        TxEn   <= 1'b0;
                        TxEr   <= 1'b0;
                        TxData <= 8'h00;
                        if (cnt == IFG_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Gnt   <= 2'b00;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgmii_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rgmii_tx_scheduler
//
// Purpose: directed self-checking bench for rgmii_tx_scheduler. A default
// instance covers single frames, arbitration, underrun, rate strobing, link
// loss and reset; a second instance with PRE_BYTES=3, IFG_BYTES=4 covers the
// parameterised framing. Expected per-slot outputs are packed as
// {Gnt[1:0], TxEn, TxEr, TxData[7:0]}.
// -----------------------------------------------------------------------------
module tb_rgmii_tx_scheduler;

    logic       Clk;
    logic       Reset_n;
    logic       ClkEn;
    logic       LinkUp;
    logic [1:0] Req, Gnt, SrcVld, SrcLast, SrcRd;
    logic [7:0] SrcData0, SrcData1, TxData;
    logic       TxEn, TxEr, Busy;
    logic [2:0] FsmState;

    logic [1:0] Req_b, Gnt_b, SrcVld_b, SrcLast_b, SrcRd_b;
    logic [7:0] SrcData0_b, TxData_b;
    logic       TxEn_b, TxEr_b, Busy_b;
    logic [2:0] FsmState_b;

    int checks = 0;
    int passes = 0;
    logic [11:0] exp_q[$];

    rgmii_tx_scheduler dut (
        .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .LinkUp(LinkUp),
        .Req(Req), .Gnt(Gnt), .SrcVld(SrcVld), .SrcLast(SrcLast),
        .SrcData0(SrcData0), .SrcData1(SrcData1), .SrcRd(SrcRd),
        .TxEn(TxEn), .TxEr(TxEr), .TxData(TxData), .Busy(Busy),
        .FsmState(FsmState)
    );

    rgmii_tx_scheduler #(.PRE_BYTES(3), .IFG_BYTES(4)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .LinkUp(LinkUp),
        .Req(Req_b), .Gnt(Gnt_b), .SrcVld(SrcVld_b), .SrcLast(SrcLast_b),
        .SrcData0(SrcData0_b), .SrcData1(8'h00), .SrcRd(SrcRd_b),
        .TxEn(TxEn_b), .TxEr(TxEr_b), .TxData(TxData_b), .Busy(Busy_b),
        .FsmState(FsmState_b)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- source models ----------------
    function automatic logic [7:0] src_byte(input int r, input int f, input int i);
        return 8'((i * 7 + r * 64 + f * 13 + 1) & 255);
    endfunction

    int pop_cnt[2] = '{0, 0};
    int src_base[2] = '{0, 0};
    int src_len[2] = '{1, 1};
    int src_gap[2] = '{-1, -1};
    bit src_on[2] = '{1'b0, 1'b0};
    int pop_cnt_b = 0;
    int base_b = 0;
    int len_b = 1;
    bit on_b = 1'b0;

    always @(posedge Clk) begin
        for (int r = 0; r < 2; r++) begin
            if (SrcRd[r]) pop_cnt[r] <= pop_cnt[r] + 1;
        end
        if (SrcRd_b[0]) pop_cnt_b <= pop_cnt_b + 1;
    end

    int n0, n1, nb, idx0, idx1, idxb, fn0, fn1, fnb;
    assign n0   = pop_cnt[0] - src_base[0];
    assign n1   = pop_cnt[1] - src_base[1];
    assign nb   = pop_cnt_b - base_b;
    assign idx0 = n0 % src_len[0];
    assign idx1 = n1 % src_len[1];
    assign idxb = nb % len_b;
    assign fn0  = n0 / src_len[0];
    assign fn1  = n1 / src_len[1];
    assign fnb  = nb / len_b;

    assign SrcVld[0]   = src_on[0] && !((fn0 == 0) && (idx0 == src_gap[0]));
    assign SrcVld[1]   = src_on[1] && !((fn1 == 0) && (idx1 == src_gap[1]));
    assign SrcLast[0]  = (idx0 == src_len[0] - 1);
    assign SrcLast[1]  = (idx1 == src_len[1] - 1);
    assign SrcData0    = src_byte(0, fn0, idx0);
    assign SrcData1    = src_byte(1, fn1, idx1);
    assign SrcVld_b    = {1'b0, on_b};
    assign SrcLast_b   = {1'b0, (idxb == len_b - 1)};
    assign SrcData0_b  = src_byte(2, fnb, idxb);

    // ---------------- driver tasks ----------------
    task automatic src_start(input int r, input int len, input int gap);
        src_base[r] = pop_cnt[r];
        src_len[r]  = len;
        src_gap[r]  = gap;
        src_on[r]   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Expected slots for one frame plus its gap. gap >= 0 means the
    // frame aborts after 'gap' accepted data bytes.
    task automatic build_frame(input logic [1:0] g, input int r, input int f,
                               input int pre, input int len, input int gap,
                               input int ifg);
        for (int p = 0; p < pre; p++) exp_q.push_back({g, 2'b10, 8'h55});
        exp_q.push_back({g, 2'b10, 8'hD5});
        if (gap < 0) begin
            for (int i = 0; i < len; i++)
                exp_q.push_back({(i == len - 1) ? 2'b00 : g, 2'b10, src_byte(r, f, i)});
        end else begin
            for (int i = 0; i < gap; i++)
                exp_q.push_back({g, 2'b10, src_byte(r, f, i)});
            exp_q.push_back({2'b00, 2'b11, 8'h00});
        end
        for (int i = 0; i < ifg; i++) exp_q.push_back(12'h000);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [17:0] o;
        Reset_n = 1'b0;
        ClkEn   = 1'b0;   // reset must act even without a slot strobe
        repeat (3) @(negedge Clk);
        o = {Gnt, SrcRd, TxEn, TxEr, TxData, Busy, FsmState};
        checks++;
        if (o !== 18'h0) $display("FAIL reset_a: got %h want 00000", o); else passes++;
        o = {Gnt_b, SrcRd_b, TxEn_b, TxEr_b, TxData_b, Busy_b, FsmState_b};
        checks++;
        if (o !== 18'h0) $display("FAIL reset_b: got %h want 00000", o); else passes++;
        Reset_n = 1'b1;
        ClkEn   = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_single_frame();
        logic [11:0] e, o;
        int n;
        exp_q.delete();
        build_frame(2'b01, 0, 0, 7, 64, -1, 12);
        n = exp_q.size();
        src_start(0, 64, -1);
        Req = 2'b01;
        for (int s = 0; s < n; s++) begin
            @(negedge Clk);
            Req = 2'b00;  // dropping Req mid-frame must not end the frame
            e = exp_q.pop_front();
            o = {Gnt, TxEn, TxEr, TxData};
            checks++;
            if (o !== e) $display("FAIL single slot %0d: got %h want %h", s + 1, o, e);
            else passes++;
            if (s == 30) begin
                checks++;
                if (Busy !== 1'b1) $display("FAIL single busy: got %b want 1", Busy); else passes++;
            end
        end
        checks++;
        if (Busy !== 1'b0) $display("FAIL single idle busy: got %b want 0", Busy); else passes++;
        src_on[0] = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [11:0] e, o;
        int n;
        do_reset();
        exp_q.delete();
        build_frame(2'b01, 0, 0, 7, 60, -1, 12);
        build_frame(2'b10, 1, 0, 7, 60, -1, 12);
        build_frame(2'b01, 0, 1, 7, 60, -1, 12);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        n = exp_q.size();
        src_start(0, 60, -1);
        src_start(1, 60, -1);
        Req = 2'b11;
        for (int s = 0; s < n; s++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            o = {Gnt, TxEn, TxEr, TxData};
            checks++;
            if (o !== e) $display("FAIL arb slot %0d: got %h want %h", s + 1, o, e);
            else passes++;
            if (s == 160) Req = 2'b00;
        end
        src_on[0] = 1'b0;
        src_on[1] = 1'b0;
    endtask

    task automatic test_underrun();
        logic [11:0] e, o;
        int n;
        exp_q.delete();
        build_frame(2'b01, 0, 0, 7, 64, 9, 12);
        n = exp_q.size();
        src_start(0, 64, 9);
        Req = 2'b01;
        for (int s = 0; s < n; s++) begin
            @(negedge Clk);
            Req = 2'b00;
            e = exp_q.pop_front();
            o = {Gnt, TxEn, TxEr, TxData};
            checks++;
            if (o !== e) $display("FAIL underrun slot %0d: got %h want %h", s + 1, o, e);
            else passes++;
        end
        checks++;
        if (Busy !== 1'b0) $display("FAIL underrun idle busy: got %b want 0", Busy); else passes++;
        src_on[0] = 1'b0;
    endtask

    task automatic test_rate_enable();
        logic [11:0] e, o;
        int n, pulses;
        pulses = 0;
        exp_q.delete();
        build_frame(2'b01, 0, 0, 7, 60, -1, 12);
        n = exp_q.size();
        src_start(0, 60, -1);
        Req   = 2'b01;
        ClkEn = 1'b1;
        for (int s = 0; s < n; s++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 10; c++) begin
                @(negedge Clk);
                Req = 2'b00;
                o = {Gnt, TxEn, TxEr, TxData};
                checks++;
                if (o !== e) $display("FAIL rate slot %0d cyc %0d: got %h want %h", s + 1, c, o, e);
                else passes++;
                ClkEn = (c == 9);
                #1;
                if (ClkEn) begin
                    if (SrcRd !== 2'b00) pulses++;
                end else begin
                    checks++;
                    if (SrcRd !== 2'b00) $display("FAIL rate srcrd_idle: got %b want 00", SrcRd);
                    else passes++;
                end
            end
        end
        checks++;
        if (pulses !== 60) $display("FAIL rate pops: got %0d want 60", pulses); else passes++;
        ClkEn = 1'b1;
        src_on[0] = 1'b0;
    endtask

    task automatic test_link_and_reset();
        logic [11:0] e, o;
        logic [17:0] z;
        int n;
        // Link down: requests are not granted.
        LinkUp = 1'b0;
        Req    = 2'b01;
        src_start(0, 64, -1);
        for (int s = 0; s < 8; s++) begin
            @(negedge Clk);
            checks++;
            if ({Gnt, TxEn, Busy} !== 4'b0000)
                $display("FAIL linkdown: got %b want 0000", {Gnt, TxEn, Busy});
            else passes++;
        end
        LinkUp = 1'b1;
        // Link drop during payload: one error slot, no pop in that slot.
        // The shape equals an abort after 5 accepted data bytes.
        exp_q.delete();
        build_frame(2'b01, 0, 0, 7, 64, 5, 12);
        n = exp_q.size();
        for (int s = 0; s < n; s++) begin
            @(negedge Clk);
            Req = 2'b00;
            e = exp_q.pop_front();
            o = {Gnt, TxEn, TxEr, TxData};
            checks++;
            if (o !== e) $display("FAIL linkdrop slot %0d: got %h want %h", s + 1, o, e);
            else passes++;
            if (s == 12) begin
                LinkUp = 1'b0;
                #1;
                checks++;
                if (SrcRd !== 2'b00) $display("FAIL linkdrop srcrd: got %b want 00", SrcRd);
                else passes++;
            end
            if (s == 13) LinkUp = 1'b1;
        end
        // Reset in the middle of the preamble.
        src_start(0, 64, -1);
        Req = 2'b01;
        repeat (3) @(negedge Clk);
        Req = 2'b00;
        checks++;
        if ({TxEn, TxData} !== 9'h155) $display("FAIL midpre pre: got %h want 155", {TxEn, TxData});
        else passes++;
        Reset_n = 1'b0;
        @(negedge Clk);
        z = {Gnt, SrcRd, TxEn, TxEr, TxData, Busy, FsmState};
        checks++;
        if (z !== 18'h0) $display("FAIL midpre reset: got %h want 00000", z); else passes++;
        Reset_n = 1'b1;
        src_on[0] = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_parameters();
        logic [11:0] e, o;
        int n;
        exp_q.delete();
        build_frame(2'b01, 2, 0, 3, 8, -1, 4);
        build_frame(2'b01, 2, 1, 3, 8, -1, 4);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        n = exp_q.size();
        base_b = pop_cnt_b;
        len_b  = 8;
        on_b   = 1'b1;
        Req_b  = 2'b01;
        for (int s = 0; s < n; s++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            o = {Gnt_b, TxEn_b, TxEr_b, TxData_b};
            checks++;
            if (o !== e) $display("FAIL param slot %0d: got %h want %h", s + 1, o, e);
            else passes++;
            if (s == 16) Req_b = 2'b00;
        end
        on_b = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Reset_n = 1'b0;
        ClkEn   = 1'b1;
        LinkUp  = 1'b1;
        Req     = 2'b00;
        Req_b   = 2'b00;
        test_reset();
        test_single_frame();
        test_arbitration();
        test_underrun();
        test_rate_enable();
        test_link_and_reset();
        test_parameters();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
